// File: rtl/img_pkg.sv
// Shared definitions for the image-processing front end: pixel width default,
// median window height and the column generator state encoding.
package img_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int WIN_ROWS       = 7;
  localparam int LINE_COUNT     = WIN_ROWS - 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

endpackage

// File: rtl/line_ram.sv
// One image row of storage with a registered, read-first output. Reads and the
// deferred cascade write use separate addresses so it maps onto a simple dual-port block RAM.
module line_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-first: a read and write to the same address return the old word.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/column_window_gen.sv
// Buffers six previous rows and emits the 7-pixel vertical column for every
// incoming pixel once row 6 of a frame is reached, with a row-start refresh pulse.
module column_window_gen
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = 640,
  parameter int X_W        = $clog2(IMG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [DATA_WIDTH-1:0] col0,
  output logic [DATA_WIDTH-1:0] col1,
  output logic [DATA_WIDTH-1:0] col2,
  output logic [DATA_WIDTH-1:0] col3,
  output logic [DATA_WIDTH-1:0] col4,
  output logic [DATA_WIDTH-1:0] col5,
  output logic [DATA_WIDTH-1:0] col6,
  output logic                  col_valid,
  output logic                  refresh
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);

  state_t state, state_next;
  logic [X_W-1:0] x_cnt, x_cur, wr_addr;
  logic [2:0] y_cnt;
  logic accept, emit, row_done, wr_pend, s1_valid;
  logic [DATA_WIDTH-1:0] pix_d;
  logic [DATA_WIDTH-1:0] line_rd [LINE_COUNT];
  logic [DATA_WIDTH-1:0] col_q [WIN_ROWS];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (pix_valid && sof)
      state_next = FILL;
    else if (pix_valid && state == FILL && x_cnt == X_LAST && y_cnt == 3'd5)
      state_next = STREAM;
  end

  always_comb begin
    accept   = pix_valid && (sof || state != IDLE);
    emit     = pix_valid && !sof && state == STREAM;
    x_cur    = sof ? '0 : x_cnt;
    row_done = !sof && x_cnt == X_LAST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (sof) begin
        x_cnt <= X_W'(1);
        y_cnt <= '0;
      end else if (row_done) begin
        x_cnt <= '0;
        if (y_cnt != 3'd6) y_cnt <= y_cnt + 3'd1;
      end else begin
        x_cnt <= x_cnt + X_W'(1);
      end
    end
  end

  // Stage 1. Each cascade write is deferred to the next accepted pixel, when the
  // upstream line's old word at that column has arrived on its read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      pix_d    <= '0;
      s1_valid <= 1'b0;
      refresh  <= 1'b0;
    end else begin
      s1_valid <= emit;
      refresh  <= emit && x_cnt == '0;
      if (accept) begin
        wr_pend <= 1'b1;
        wr_addr <= x_cur;
        pix_d   <= pix_in;
      end
    end
  end

  for (genvar k = 0; k < LINE_COUNT; k++) begin : g_line
    logic [DATA_WIDTH-1:0] wdata;
    if (k == 0) begin : g_head
      assign wdata = pix_d;
    end else begin : g_tail
      assign wdata = line_rd[k-1];
    end

    line_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH),
      .ADDR_W    (X_W)
    ) u_line (
      .clk    (clk),
      .rd_en  (accept),
      .rd_addr(x_cur),
      .rd_data(line_rd[k]),
      .wr_en  (accept && wr_pend),
      .wr_addr(wr_addr),
      .wr_data(wdata)
    );
  end

  // Stage 2 only loads on a real column, so outputs hold across stalls and FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_valid <= 1'b0;
      for (int i = 0; i < WIN_ROWS; i++) col_q[i] <= '0;
    end else begin
      col_valid <= s1_valid;
      if (s1_valid) begin
        col_q[WIN_ROWS-1] <= pix_d;
        for (int k = 0; k < LINE_COUNT; k++) col_q[LINE_COUNT-1-k] <= line_rd[k];
      end
    end
  end

  assign col0 = col_q[0];
  assign col1 = col_q[1];
  assign col2 = col_q[2];
  assign col3 = col_q[3];
  assign col4 = col_q[4];
  assign col5 = col_q[5];
  assign col6 = col_q[6];

endmodule

// File: tb/tb_column_window_gen.sv
// Table-driven bench for column_window_gen on an 8-pixel-wide image where each
// pixel is base + y*16 + x in its own frame coordinates.
module tb_column_window_gen;

  localparam int IMG_W = 8;

  typedef struct {
    logic       rst;
    logic       v;
    logic       sof;
    logic [7:0] pix;
    logic       emit;
    int         y;
    int         x;
    logic [7:0] base;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        refresh;
    logic [55:0] cols;
  } exp_t;

  logic clk, rst, sof, pix_valid;
  logic [7:0] pix_in;
  logic [7:0] col0, col1, col2, col3, col4, col5, col6;
  logic col_valid, refresh;

  vec_t vecs[$];
  exp_t exps[$];
  int gy, gx;
  bit in_frame;
  logic [7:0] gbase;
  int passed, total;

  column_window_gen #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (IMG_W),
    .X_W       (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sof      (sof),
    .pix_valid(pix_valid),
    .pix_in   (pix_in),
    .col0     (col0),
    .col1     (col1),
    .col2     (col2),
    .col3     (col3),
    .col4     (col4),
    .col5     (col5),
    .col6     (col6),
    .col_valid(col_valid),
    .refresh  (refresh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task pushPixel(input bit start);
    vec_t r;
    if (start) begin
      in_frame = 1'b1;
      gy = 0;
      gx = 0;
    end
    r.rst  = 1'b0;
    r.v    = 1'b1;
    r.sof  = start;
    r.y    = gy;
    r.x    = gx;
    r.base = gbase;
    r.pix  = gbase + 8'(gy * 16 + gx);
    r.emit = in_frame && gy >= 6;
    vecs.push_back(r);
    if (in_frame) begin
      if (gx == IMG_W - 1) begin
        gx = 0;
        gy++;
      end else begin
        gx++;
      end
    end
  endtask

  task pushIdle(input bit s);
    vec_t r;
    r.rst = 1'b0; r.v = 1'b0; r.sof = s; r.pix = 8'hEE;
    r.emit = 1'b0; r.y = 0; r.x = 0; r.base = 8'h00;
    vecs.push_back(r);
  endtask

  task pushReset();
    vec_t r;
    r.rst = 1'b1; r.v = 1'b1; r.sof = 1'b0; r.pix = 8'h55;
    r.emit = 1'b0; r.y = 0; r.x = 0; r.base = 8'h00;
    vecs.push_back(r);
    in_frame = 1'b0;
  endtask

  task pushFrame(input int rows, input int last_row_pixels, input bit gaps);
    for (int i = 0; i < rows * IMG_W + last_row_pixels; i++) begin
      if (gaps && i != 0 && $urandom_range(0, 9) < 3) pushIdle(1'b0);
      pushPixel(i == 0);
    end
  endtask

  function automatic logic [55:0] colsFor(vec_t r);
    logic [55:0] c;
    for (int k = 0; k < 7; k++) c[(6 - k) * 8 +: 8] = r.base + 8'((r.y - 6 + k) * 16 + r.x);
    return c;
  endfunction

  // Column from the pixel driven two steps back, refresh from the one driven one step back.
  task buildExpected();
    logic [55:0] last;
    exp_t e;
    last = '0;
    for (int t = 0; t < vecs.size(); t++) begin
      if (t == 0 || vecs[t-1].rst) begin
        last = '0;
        e.valid = 1'b0; e.refresh = 1'b0; e.cols = '0;
      end else begin
        e.refresh = vecs[t-1].emit && vecs[t-1].x == 0;
        if (t >= 2 && !vecs[t-2].rst && vecs[t-2].emit) begin
          last = colsFor(vecs[t-2]);
          e.valid = 1'b1;
        end else begin
          e.valid = 1'b0;
        end
        e.cols = last;
      end
      exps.push_back(e);
    end
  endtask

  task applyStimulus(input vec_t r);
    rst       = r.rst;
    pix_valid = r.v;
    sof       = r.sof;
    pix_in    = r.pix;
  endtask

  task checkOutput(input int t, input exp_t e);
    logic [55:0] act;
    act = {col0, col1, col2, col3, col4, col5, col6};
    total++;
    if (col_valid === e.valid) passed++;
    else $display("[TB] FAIL col_valid step %0d: got %b want %b", t, col_valid, e.valid);
    total++;
    if (refresh === e.refresh) passed++;
    else $display("[TB] FAIL refresh step %0d: got %b want %b", t, refresh, e.refresh);
    total++;
    if (act === e.cols) passed++;
    else $display("[TB] FAIL columns step %0d: got %h want %h", t, act, e.cols);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    in_frame = 1'b0;
    gy = 0; gx = 0;
    gbase = 8'h00;
    rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;

    pushReset();
    pushReset();
    // Pixels without a frame start are ignored in IDLE.
    for (int i = 0; i < 3; i++) pushPixel(1'b0);
    // Continuous frame, then a gapped frame restarting straight from STREAM.
    pushFrame(8, 0, 1'b0);
    pushIdle(1'b0);
    pushIdle(1'b0);
    pushFrame(8, 0, 1'b1);
    // Old frame with offset values cut short at row 7 x=4 by a new frame.
    gbase = 8'h80;
    pushFrame(7, 4, 1'b0);
    gbase = 8'h00;
    pushFrame(8, 0, 1'b0);
    // sof without pix_valid must not restart: the frame keeps streaming as row 8.
    pushIdle(1'b1);
    for (int i = 0; i < 3; i++) pushPixel(1'b0);
    pushIdle(1'b0);
    // Reset mid-stream, then unflagged pixels stay ignored.
    gbase = 8'h00;
    pushFrame(6, 3, 1'b0);
    pushReset();
    for (int i = 0; i < 2 * IMG_W; i++) pushPixel(1'b0);
    pushIdle(1'b0);
    pushIdle(1'b0);

    buildExpected();

    for (int t = 0; t < vecs.size(); t++) begin
      @(negedge clk);
      checkOutput(t, exps[t]);
      applyStimulus(vecs[t]);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
